// File: rtl/spi_master_arbiter.sv
// Purpose : packet-granular round-robin arbiter sharing one spi_master MOSI stream among AXI-stream requesters.
// Latency : 1 cycle from request in IDLE to grant; data/valid/last/ready are combinational pass-through while granted.
// Backpres: i_m_tready is forwarded only to the granted requester; everyone else sees ready low.
//
// Ports:
//   i_clk, i_reset_n          single clock, synchronous active-low reset
//   i_req_tdata/tvalid/tlast  requester streams, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_tready              per-requester ready (only the owner can be high)
//   o_m_tdata/tvalid/tlast    muxed stream towards the spi_master MOSI sink
//   i_m_tready                ready from the MOSI sink
//   o_grant                   registered one-hot owner, zero when no grant is held
//   o_busy                    registered, high while GRANTED or in the inter-packet GAP
//   o_timeout_err/id          one-cycle watchdog revoke pulse and the revoked index (id holds)
module spi_master_arbiter #(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] i_req_tdata,
  input  logic [NUM_REQUESTERS-1:0]            i_req_tvalid,
  input  logic [NUM_REQUESTERS-1:0]            i_req_tlast,
  output logic [NUM_REQUESTERS-1:0]            o_req_tready,
  output logic [DATA_WIDTH-1:0]                o_m_tdata,
  output logic                                 o_m_tvalid,
  output logic                                 o_m_tlast,
  input  logic                                 i_m_tready,
  output logic [NUM_REQUESTERS-1:0]            o_grant,
  output logic                                 o_busy,
  output logic                                 o_timeout_err,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    o_timeout_id
);

  localparam int IDW  = $clog2(NUM_REQUESTERS);
  localparam int IDW1 = IDW + 1;
  localparam int GCW  = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQUESTERS - 1);
  localparam logic [IDW1-1:0] N_WIDE  = IDW1'(NUM_REQUESTERS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  logic [1:0]                r_state;
  logic [NUM_REQUESTERS-1:0] r_grant;
  logic [IDW-1:0]            r_owner;
  logic [IDW-1:0]            r_rr_ptr;
  logic [GCW-1:0]            r_gap_cnt;
  logic [TCW-1:0]            r_wd_cnt;
  logic                      r_started;   // at least one beat of the current packet accepted
  logic                      r_busy;
  logic                      r_timeout_err;
  logic [IDW-1:0]            r_timeout_id;

  logic                      w_found;
  logic [IDW-1:0]            w_win;
  logic [IDW1-1:0]           w_idx;
  logic [NUM_REQUESTERS-1:0] w_win_oh;
  logic [DATA_WIDTH-1:0]     w_sel_dat;
  logic                      w_sel_vld;
  logic                      w_sel_lst;
  logic                      w_granted;
  logic                      w_fire;
  logic                      w_pkt_end;
  logic                      w_wd_trip;

  // Round-robin search upward from r_rr_ptr with wrap; the first valid wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      w_idx = {1'b0, r_rr_ptr} + IDW1'(k);
      if (w_idx >= N_WIDE) begin
        w_idx = w_idx - N_WIDE;
      end
      if (!w_found && i_req_tvalid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end
    end
  end

  assign w_win_oh = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1} << w_win;

  // Owner's stream selected by the registered owner index.
  always_comb begin
    w_sel_dat = '0;
    w_sel_vld = 1'b0;
    w_sel_lst = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (r_owner == IDW'(k)) begin
        w_sel_dat = i_req_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        w_sel_vld = i_req_tvalid[k];
        w_sel_lst = i_req_tlast[k];
      end
    end
  end

  assign w_granted = (r_state == ST_GRANTED);
  assign w_fire    = w_granted & w_sel_vld & i_m_tready;
  assign w_pkt_end = w_fire & w_sel_lst;
  // Watchdog only runs once the packet has started; an unstarted grant is held forever.
  assign w_wd_trip = w_granted & r_started & ~w_sel_vld & (r_wd_cnt == TO_LAST);

  always_comb begin
    o_m_tdata    = '0;
    o_m_tvalid   = 1'b0;
    o_m_tlast    = 1'b0;
    o_req_tready = '0;
    if (w_granted) begin
      o_m_tdata    = w_sel_dat;
      o_m_tvalid   = w_sel_vld;
      o_m_tlast    = w_sel_lst;
      o_req_tready = r_grant & {NUM_REQUESTERS{i_m_tready}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= '0;
      r_gap_cnt     <= '0;
      r_wd_cnt      <= '0;
      r_started     <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timeout_id  <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state   <= ST_GRANTED;
            r_grant   <= w_win_oh;
            r_owner   <= w_win;
            r_rr_ptr  <= (w_win == ID_LAST) ? '0 : w_win + 1'b1;
            r_busy    <= 1'b1;
            r_started <= 1'b0;
            r_wd_cnt  <= '0;
          end
        end
        ST_GRANTED: begin
          if (w_pkt_end || w_wd_trip) begin
            r_grant   <= '0;
            r_gap_cnt <= '0;
            r_wd_cnt  <= '0;
            r_started <= 1'b0;
            if (w_wd_trip) begin
              r_timeout_err <= 1'b1;
              r_timeout_id  <= r_owner;
            end
            // With no gap configured there is nothing to wait for.
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
              r_busy  <= 1'b1;
            end
          end else if (w_fire) begin
            r_started <= 1'b1;
            r_wd_cnt  <= '0;
          end else if (r_started && !w_sel_vld) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end else begin
            // Valid high but sink stalled: not a requester stall, restart the run.
            r_wd_cnt <= '0;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;
  assign o_timeout_id  = r_timeout_id;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Purpose : directed self-checking bench for spi_master_arbiter (two instances: gap=4 and gap=0).
// Latency : inputs driven 2 time units after posedge, outputs checked 1 unit later (before next edge).
// Backpres: i_m_tready is driven by the bench to exercise stalls inside a packet.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] tdata;
  logic [3:0]  tvalid;
  logic [3:0]  tlast;
  logic        m_tready;

  logic [3:0]  a_tready, a_grant;
  logic [7:0]  a_mdata;
  logic        a_mvalid, a_mlast, a_busy, a_terr;
  logic [1:0]  a_tid;

  logic [3:0]  b_tready, b_grant;
  logic [7:0]  b_mdata;
  logic        b_mvalid, b_mlast, b_busy, b_terr;
  logic [1:0]  b_tid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(
    .NUM_REQUESTERS(4), .DATA_WIDTH(8), .GAP_CYCLES(4), .TIMEOUT_CYCLES(8)
  ) u_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_tdata(tdata), .i_req_tvalid(tvalid), .i_req_tlast(tlast),
    .o_req_tready(a_tready),
    .o_m_tdata(a_mdata), .o_m_tvalid(a_mvalid), .o_m_tlast(a_mlast),
    .i_m_tready(m_tready),
    .o_grant(a_grant), .o_busy(a_busy),
    .o_timeout_err(a_terr), .o_timeout_id(a_tid)
  );

  spi_master_arbiter #(
    .NUM_REQUESTERS(4), .DATA_WIDTH(8), .GAP_CYCLES(0), .TIMEOUT_CYCLES(8)
  ) u_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_tdata(tdata), .i_req_tvalid(tvalid), .i_req_tlast(tlast),
    .o_req_tready(b_tready),
    .o_m_tdata(b_mdata), .o_m_tvalid(b_mvalid), .o_m_tlast(b_mlast),
    .i_m_tready(m_tready),
    .o_grant(b_grant), .o_busy(b_busy),
    .o_timeout_err(b_terr), .o_timeout_id(b_tid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs changed afterwards apply to the next edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with every requester offering a single-beat packet 0xA0+i.
    rst_n    = 1'b0;
    tdata    = 32'hA3A2A1A0;
    tvalid   = 4'hF;
    tlast    = 4'hF;
    m_tready = 1'b1;
    repeat (3) cyc();
    #1;
    chk("rst_grant",  a_grant,  4'h0);
    chk("rst_busy",   a_busy,   1'b0);
    chk("rst_tready", a_tready, 4'h0);
    chk("rst_mvalid", a_mvalid, 1'b0);
    chk("rst_terr",   a_terr,   1'b0);

    // Round robin: A0,A1,A2,A3,A0 with first beats 6 cycles apart.
    rst_n = 1'b1;
    cyc(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_mdata",  a_mdata,  32'hA0 + (i % 4));
      chk("rr_grant",  a_grant,  32'h1 << (i % 4));
      chk("rr_tready", a_tready, 32'h1 << (i % 4));
      chk("rr_mlast",  a_mlast,  1'b1);
      if (i < 4) begin
        for (int j = 1; j <= 5; j++) begin
          cyc(); #1;
          chk("rr_gap_mvalid", a_mvalid, 1'b0);
          chk("rr_gap_busy",   a_busy,   (j < 5) ? 1'b1 : 1'b0);
        end
        cyc(); #1;
      end
    end

    // Multi-beat hold: requester 2 sends 11,22,33 while requester 0 waits.
    cyc();
    tvalid = 4'b0101;
    tlast  = 4'b0001;
    tdata  = 32'h00_11_00_B0;
    #1;
    repeat (4) cyc();
    #1;
    chk("mb_idle_busy", a_busy, 1'b0);
    cyc(); #1;
    chk("mb1_grant",  a_grant,  4'b0100);
    chk("mb1_mdata",  a_mdata,  8'h11);
    chk("mb1_mlast",  a_mlast,  1'b0);
    chk("mb1_tready", a_tready, 4'b0100);
    cyc();
    tdata    = 32'h00_22_00_B0;
    m_tready = 1'b0;
    #1;
    chk("mb2_grant",  a_grant,  4'b0100);
    chk("mb2_mdata",  a_mdata,  8'h22);
    chk("mb2_tready", a_tready, 4'b0000);
    chk("mb2_mvalid", a_mvalid, 1'b1);
    cyc();
    m_tready = 1'b1;
    #1;
    chk("mb3_mdata",  a_mdata,  8'h22);
    chk("mb3_tready", a_tready, 4'b0100);
    cyc();
    tdata    = 32'h00_33_00_B0;
    tlast    = 4'b0101;
    m_tready = 1'b0;
    #1;
    chk("mb4_grant",  a_grant,  4'b0100);
    chk("mb4_mdata",  a_mdata,  8'h33);
    chk("mb4_mlast",  a_mlast,  1'b1);
    chk("mb4_tready", a_tready, 4'b0000);
    cyc();
    m_tready = 1'b1;
    #1;
    chk("mb5_mdata",  a_mdata,  8'h33);
    chk("mb5_tready", a_tready, 4'b0100);
    cyc();
    tvalid = 4'b0001;
    #1;
    chk("mb_gap_grant",  a_grant,  4'b0000);
    chk("mb_gap_mvalid", a_mvalid, 1'b0);
    chk("mb_gap_busy",   a_busy,   1'b1);
    repeat (3) cyc();
    cyc(); #1;
    chk("mb_idle_grant", a_grant, 4'b0000);
    cyc(); #1;
    chk("mb_r0_grant", a_grant, 4'b0001);
    chk("mb_r0_mdata", a_mdata, 8'hB0);

    // Watchdog: requester 1 sends one non-last beat, then stalls.
    cyc();
    tvalid = 4'b0010;
    tlast  = 4'b0000;
    tdata  = 32'h00_00_55_00;
    #1;
    repeat (3) cyc();
    cyc(); #1;
    chk("wd_idle_busy", a_busy, 1'b0);
    cyc(); #1;
    chk("wd_w1_grant", a_grant, 4'b0010);
    chk("wd_w1_mdata", a_mdata, 8'h55);
    for (int k = 2; k <= 9; k++) begin
      cyc();
      if (k == 2) tvalid = 4'b0000;
      #1;
      chk("wd_stall_grant",  a_grant,  4'b0010);
      chk("wd_stall_terr",   a_terr,   1'b0);
      chk("wd_stall_mvalid", a_mvalid, 1'b0);
    end
    cyc(); #1;
    chk("wd_terr",  a_terr,  1'b1);
    chk("wd_tid",   a_tid,   2'd1);
    chk("wd_grant", a_grant, 4'b0000);
    chk("wd_busy",  a_busy,  1'b1);
    cyc(); #1;
    chk("wd_terr_pulse", a_terr, 1'b0);
    chk("wd_tid_hold",   a_tid,  2'd1);
    chk("wd_gap_busy",   a_busy, 1'b1);
    cyc(); cyc(); #1;
    chk("wd_gap_end_busy", a_busy, 1'b1);
    cyc(); #1;
    chk("wd_idle_after_gap", a_busy, 1'b0);

    // GAP_CYCLES=0 instance: back-to-back single-beat packets from requester 3.
    rst_n  = 1'b0;
    tvalid = 4'b1000;
    tlast  = 4'b1000;
    tdata  = 32'hC3_00_00_00;
    #1;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("g0_idle_busy",   b_busy,   1'b0);
    chk("g0_idle_tready", b_tready, 4'b0000);
    cyc(); #1;
    chk("g0_p1_tready", b_tready, 4'b1000);
    chk("g0_p1_grant",  b_grant,  4'b1000);
    chk("g0_p1_mdata",  b_mdata,  8'hC3);
    cyc(); #1;
    chk("g0_mid_tready", b_tready, 4'b0000);
    chk("g0_mid_busy",   b_busy,   1'b0);
    chk("g0_mid_grant",  b_grant,  4'b0000);
    cyc(); #1;
    chk("g0_p2_tready", b_tready, 4'b1000);
    chk("g0_terr",      b_terr,   1'b0);

    // Mid-packet reset: requester 2 starts a 4-beat packet, reset after beat 2.
    rst_n  = 1'b0;
    tvalid = 4'b0100;
    tlast  = 4'b0000;
    tdata  = 32'h00_01_00_00;
    #1;
    cyc();
    rst_n = 1'b1;
    #1;
    cyc(); #1;
    chk("mr_b1_grant", a_grant, 4'b0100);
    chk("mr_b1_mdata", a_mdata, 8'h01);
    cyc();
    tdata = 32'h00_02_00_00;
    #1;
    chk("mr_b2_mdata", a_mdata, 8'h02);
    cyc();
    tdata  = 32'hD3_03_00_D0;
    tvalid = 4'b1101;
    rst_n  = 1'b0;
    #1;
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mr_grant",  a_grant,  4'b0000);
    chk("mr_busy",   a_busy,   1'b0);
    chk("mr_terr",   a_terr,   1'b0);
    chk("mr_tid",    a_tid,    2'd0);
    chk("mr_mvalid", a_mvalid, 1'b0);
    chk("mr_tready", a_tready, 4'b0000);
    cyc(); #1;
    chk("mr_next_grant", a_grant, 4'b0001);
    chk("mr_next_mdata", a_mdata, 8'hD0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Packet-granular round-robin arbiter that shares one `spi_master` MOSI stream between `NUM_REQUESTERS` AXI-stream requesters. A grant is held from the first accepted beat until the beat carrying `tlast` is accepted. After each packet it enforces a programmable idle gap so the SPI master can finish its last byte and release CS. A watchdog revokes grants from requesters that stall mid-packet. Sits between register-access engines or DMA front-ends and the single `spi_master` instance.

## Interface
- `NUM_REQUESTERS`, 4: number of requester ports, 2..16.
- `DATA_WIDTH`, 8: beat width; must equal the `spi_master` `TRANSFER_WIDTH`.
- `GAP_CYCLES`, 1000: idle cycles between packets, 0..65535. Default is ≥ one 8-bit SPI frame at 100 MHz/1 MHz.
- `TIMEOUT_CYCLES`, 4096: consecutive mid-packet cycles with granted `tvalid` low before the grant is revoked, ≥1.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, synchronous, active-low.
- `req_tdata`  in  NUM_REQUESTERS*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_tvalid`  in  NUM_REQUESTERS  per-requester valid.
- `req_tlast`  in  NUM_REQUESTERS  per-requester end of packet.
- `req_tready`  out  NUM_REQUESTERS  per-requester ready.
- `m_tdata`  out  DATA_WIDTH  to `spi_master` MOSI sink.
- `m_tvalid`  out  1  to the MOSI sink.
- `m_tlast`  out  1  to the MOSI sink.
- `m_tready`  in  1  from the MOSI sink.
- `grant`  out  NUM_REQUESTERS  one-hot current owner; all zero when no grant is held.
- `busy`  out  1  high in GRANTED or GAP.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- `timeout_id`  out  $clog2(NUM_REQUESTERS)  index of the revoked requester; valid with `timeout_err`, holds its value otherwise.

## Operation
- States: IDLE, GRANTED, GAP.
- IDLE:
  - If any `req_tvalid` is high, select the first requester with valid high, searching upward from `rr_ptr` with wrap.
  - Register its one-hot in `grant` and go to GRANTED. `rr_ptr` is set to the winner+1 (mod N).
  - No beat is accepted in the IDLE cycle.
- GRANTED, with owner g:
  - Combinational pass-through: `m_tdata`=`req_tdata[g]`, `m_tvalid`=`req_tvalid[g]`, `m_tlast`=`req_tlast[g]`, `req_tready[g]`=`m_tready`.
  - All other `req_tready` are 0.
- Packet end: the beat with `m_tvalid & m_tready & m_tlast` goes to GAP with gap counter = 0 and clears `grant`. If `GAP_CYCLES`=0, go directly to IDLE.
- GAP: the counter increments each cycle. When it reaches `GAP_CYCLES`-1, go to IDLE. No grant is held, all readies are 0, `m_tvalid`=0.
- Watchdog:
  - Counts consecutive GRANTED cycles in which `req_tvalid[g]` is 0 and at least one beat of the packet has already been accepted. Any accepted beat clears it.
  - On reaching `TIMEOUT_CYCLES`: pulse `timeout_err`, set `timeout_id`=g, clear `grant`, and go to GAP. Bytes already sent are not retracted.
  - Before the first beat of a packet, the grant is held indefinitely; that requester's tvalid was high at grant time.
- Outside GRANTED: `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `req_tready`=0.
- Reset (`reset_n` low at a clk edge): state IDLE, `grant`=0, `busy`=0, `timeout_err`=0, `timeout_id`=0, `rr_ptr`=0, all counters 0. This applies mid-packet as well: the packet is abandoned with no error pulse.
- Counter widths: sized to hold `GAP_CYCLES` and `TIMEOUT_CYCLES`; they saturate, never wrap.

## Timing
- Grant latency: 1 cycle from `req_tvalid` rising in IDLE to `grant` and `req_tready` pass-through. The first beat can be accepted in the 2nd cycle.
- Throughput inside a packet: limited only by `m_tready`. Data paths add zero latency (combinational).
- Packet-to-packet, same or different requester: last beat, then `GAP_CYCLES` cycles of GAP, then 1 IDLE cycle, then the next first-beat opportunity.
- `busy`, `grant`, `timeout_err` and `timeout_id` are registered outputs.
- Simultaneous request and `tlast` acceptance: requests arriving during GRANTED or GAP wait. Arbitration happens only in IDLE, using `rr_ptr`, so a requester that was just served has lowest priority.
- A requester dropping `tvalid` before it is granted is legal. Arbitration samples only the IDLE cycle.

## Test plan
- Reset values: hold `reset_n`=0 for 3 cycles with all requests high → `grant`=0, `busy`=0, all `req_tready`=0, `m_tvalid`=0.
- Round robin: N=4 and GAP_CYCLES=4, all four requesters continuously offer single-beat packets (0xA0+i, tlast=1), `m_tready`=1 → `m_tdata` sequence A0,A1,A2,A3,A0. First beats are spaced 6 cycles apart.
- Multi-beat hold: requester 2 sends a 3-beat packet (11,22,33) while requester 0 is requesting → `grant` stays 4'b0100 through 33, then requester 0 is granted after the gap. `m_tready` toggling 1,0,1,0 delays beats but never interleaves them.
- Watchdog: TIMEOUT_CYCLES=8, requester 1 sends one non-last beat then drops tvalid → after 8 cycles `timeout_err` pulses for 1 cycle, `timeout_id`=1, `grant`=0, then GAP.
- GAP_CYCLES=0: back-to-back packets from requester 3 → exactly 1 IDLE cycle between the last beat and the next `req_tready` high.
- Mid-packet reset: assert `reset_n`=0 after the 2nd of 4 beats → the next cycle is IDLE with all outputs at reset values, no `timeout_err`, and `rr_ptr` back to 0, so requester 0 wins next.
